// File: rtl/gray_codec_fifo_pkg.sv
// gray_codec_fifo_pkg: register map, bit positions and conversion mode shared by the FIFO peripheral
package gray_codec_fifo_pkg;
    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_CTL    = 3'd1;
    localparam logic [2:0] ADDR_STAT   = 3'd2;
    localparam logic [2:0] ADDR_THRESH = 3'd3;
    localparam logic [2:0] ADDR_LEVEL  = 3'd4;
    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_OVF   = 2;
    localparam int STAT_UNF   = 3;
    localparam int CTL_MODE  = 0;
    localparam int CTL_CLEAR = 1;
    typedef enum logic {MODE_B2G = 1'b0, MODE_G2B = 1'b1} mode_t;
endpackage

// File: rtl/gray_codec.sv
// gray_codec: combinational binary->Gray or Gray->binary conversion of one word
module gray_codec
    import gray_codec_fifo_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] in,
    input  mode_t         mode,
    output logic [DW-1:0] out
);
    logic [DW-1:0] bin;
    // Gray->binary: each bit is the XOR of itself and every bit above it
    always_comb begin
        bin = in;
        for (int i = 1; i < DW; i++) bin = bin ^ (in >> i);
    end
    assign out = (mode == MODE_G2B) ? bin : in ^ (in >> 1);
endmodule

// File: rtl/gray_codec_fifo.sv
// gray_codec_fifo: register-mapped FIFO that Gray-encodes or decodes each pushed word
module gray_codec_fifo
    import gray_codec_fifo_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [2:0]    addr,
    input  logic          write,
    input  logic          read,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          resp,
    output logic          irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level, level_next, thresh;
    logic [DW-1:0] conv;
    mode_t         mode;
    logic          ovf, unf;

    gray_codec #(.DW(DW)) u_codec (.in(wdata), .mode(mode), .out(conv));

    logic wr, rd, push, pop, empty, full, push_ok, pop_ok, clear, ctl_wr;
    assign wr      = enable && write;
    assign rd      = enable && read;
    assign push    = wr && addr == ADDR_DATA;
    assign pop     = rd && addr == ADDR_DATA;
    assign empty   = level == '0;
    assign full    = level == LW'(DEPTH);
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign ctl_wr  = wr && addr == ADDR_CTL;
    assign clear   = ctl_wr && wdata[CTL_CLEAR];
    assign level_next = clear ? '0 :
                        (push_ok && !pop_ok) ? level + LW'(1) :
                        (!push_ok && pop_ok) ? level - LW'(1) : level;

    // error response for reserved/read-only writes, dropped pushes and empty pops
    assign resp = enable && ((addr > ADDR_LEVEL && (read || write)) ||
                  (write && (addr == ADDR_STAT || addr == ADDR_LEVEL)) ||
                  (push && full && !pop) || (pop && empty));

    // combinational register read; DATA shows the head entry without popping
    always_comb begin
        rdata = '0;
        if (enable) begin
            case (addr)
                ADDR_DATA:   rdata = empty ? '0 : mem[rd_ptr];
                ADDR_CTL:    rdata[CTL_MODE] = mode;
                ADDR_STAT: begin
                    rdata[STAT_EMPTY] = empty;
                    rdata[STAT_FULL]  = full;
                    rdata[STAT_OVF]   = ovf;
                    rdata[STAT_UNF]   = unf;
                end
                ADDR_THRESH: rdata = DW'(thresh);
                ADDR_LEVEL:  rdata = DW'(level);
                default:     rdata = '0;
            endcase
        end
    end

    // storage needs no reset; entries are only visible through the level count
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= conv;
    end

    // pointers, level, control registers, sticky flags and registered interrupt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            thresh <= '0;
            mode   <= MODE_B2G;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            irq    <= 1'b0;
        end else begin
            level <= level_next;
            irq   <= (thresh != '0) && (level_next >= thresh);
            if (ctl_wr) mode <= mode_t'(wdata[CTL_MODE]);
            if (wr && addr == ADDR_THRESH) thresh <= LW'(wdata);
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                ovf    <= 1'b0;
                unf    <= 1'b0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
                if (push && full && !pop) ovf <= 1'b1;
                if (pop && empty) unf <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_gray_codec_fifo.sv
// tb_gray_codec_fifo: directed register-level checks of gray_codec_fifo (DW=8, DEPTH=4)
module tb_gray_codec_fifo;
    import gray_codec_fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] addr = '0;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       resp;
    logic       irq;
    int vectors = 0;
    int miscompares = 0;

    gray_codec_fifo #(.DW(8), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .addr(addr), .write(write),
        .read(read), .wdata(wdata), .rdata(rdata), .resp(resp), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one bus cycle: drive on the falling edge, outputs settle before the next rising edge
    task automatic bus(input logic en, input logic [2:0] a, input logic w, input logic r, input logic [7:0] d);
        @(negedge clk);
        enable = en; addr = a; write = w; read = r; wdata = d;
        #1;
    endtask

    task automatic peek(input string tag, input logic [2:0] a, input logic [7:0] exp);
        bus(1'b1, a, 1'b0, 1'b0, 8'h00);
        chk(tag, rdata, exp);
    endtask

    task automatic push(input string tag, input logic [7:0] d, input logic exp_resp);
        bus(1'b1, ADDR_DATA, 1'b1, 1'b0, d);
        chk(tag, resp, exp_resp);
    endtask

    task automatic pop(input string tag, input logic [7:0] exp);
        bus(1'b1, ADDR_DATA, 1'b0, 1'b1, 8'h00);
        chk(tag, rdata, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus(1'b1, a, 1'b1, 1'b0, d);
    endtask

    task automatic idle();
        bus(1'b0, ADDR_DATA, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_irq", irq, 1'b0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_resp", resp, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        peek("rst_stat", ADDR_STAT, 8'h01);
        peek("rst_level", ADDR_LEVEL, 8'h00);
        peek("rst_ctl", ADDR_CTL, 8'h00);

        push("push05_resp", 8'h05, 1'b0);
        peek("level1", ADDR_LEVEL, 8'h01);
        peek("head_b2g_05", ADDR_DATA, 8'h07);
        pop("pop_b2g_05", 8'h07);
        chk("pop_resp", resp, 1'b0);
        peek("level0", ADDR_LEVEL, 8'h00);
        peek("stat_empty", ADDR_STAT, 8'h01);

        push("pushFF_m0", 8'hFF, 1'b0);
        wr(ADDR_CTL, 8'h01);
        peek("ctl_mode1", ADDR_CTL, 8'h01);
        push("push07_m1", 8'h07, 1'b0);
        pop("pop_b2g_FF", 8'h80);
        pop("pop_g2b_07", 8'h05);
        push("pushFF_m1", 8'hFF, 1'b0);
        wr(ADDR_CTL, 8'h00);
        pop("pop_g2b_FF", 8'hAA);

        push("fill1", 8'h01, 1'b0);
        push("fill2", 8'h02, 1'b0);
        push("fill3", 8'h03, 1'b0);
        push("fill4", 8'h04, 1'b0);
        push("push_full_resp", 8'h05, 1'b1);
        peek("stat_full_ovf", ADDR_STAT, 8'h06);
        peek("level_full", ADDR_LEVEL, 8'h04);
        bus(1'b1, ADDR_DATA, 1'b1, 1'b1, 8'h08);
        chk("pushpop_full_rdata", rdata, 8'h01);
        chk("pushpop_full_resp", resp, 1'b0);
        peek("level_pushpop", ADDR_LEVEL, 8'h04);
        peek("stat_pushpop", ADDR_STAT, 8'h06);
        pop("drain_03", 8'h03);
        pop("drain_02", 8'h02);
        pop("drain_06", 8'h06);
        pop("drain_0C", 8'h0C);

        pop("pop_empty_rdata", 8'h00);
        chk("pop_empty_resp", resp, 1'b1);
        peek("stat_unf", ADDR_STAT, 8'h0D);
        wr(ADDR_CTL, 8'h02);
        peek("stat_cleared", ADDR_STAT, 8'h01);
        peek("ctl_after_clear", ADDR_CTL, 8'h00);

        bus(1'b1, 3'd5, 1'b0, 1'b1, 8'h00);
        chk("rsv5_resp", resp, 1'b1);
        chk("rsv5_rdata", rdata, 8'h00);
        wr(ADDR_LEVEL, 8'h03);
        chk("wr_level_resp", resp, 1'b1);
        wr(3'd7, 8'h11);
        chk("wr_rsv7_resp", resp, 1'b1);
        peek("level_after_bad_wr", ADDR_LEVEL, 8'h00);

        wr(ADDR_THRESH, 8'h03);
        peek("thresh3", ADDR_THRESH, 8'h03);
        push("th_push1", 8'h10, 1'b0);
        push("th_push2", 8'h20, 1'b0);
        idle();
        chk("irq_level2", irq, 1'b0);
        push("th_push3", 8'h30, 1'b0);
        idle();
        idle();
        chk("irq_level3", irq, 1'b1);
        bus(1'b1, ADDR_DATA, 1'b1, 1'b1, 8'h40);
        chk("th_pushpop_rdata", rdata, 8'h18);
        idle();
        idle();
        chk("irq_hold", irq, 1'b1);
        peek("level_hold3", ADDR_LEVEL, 8'h03);
        pop("th_pop", 8'h30);
        idle();
        idle();
        chk("irq_drop", irq, 1'b0);

        wr(ADDR_THRESH, 8'h02);
        wr(ADDR_CTL, 8'h01);
        idle();
        chk("irq_thresh2", irq, 1'b1);
        peek("pre_rst_ctl", ADDR_CTL, 8'h01);
        peek("pre_rst_level", ADDR_LEVEL, 8'h02);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_level", rdata, 8'h00);
        chk("arst_irq", irq, 1'b0);
        addr = ADDR_STAT;
        #1 chk("arst_stat", rdata, 8'h01);
        addr = ADDR_CTL;
        #1 chk("arst_ctl", rdata, 8'h00);
        addr = ADDR_THRESH;
        #1 chk("arst_thresh", rdata, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        peek("post_rst_data", ADDR_DATA, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
